// File: rtl/poly_note_pitch2dds.sv
// Polyphonic note-to-DDS converter: scans one voice per cycle, glides its pitch, applies
// bend and LFO, and interpolates a note-to-phase-increment table into a 32-bit DDS adder.
module poly_note_pitch2dds #(
  parameter int VOICES   = 8,
  parameter int NOTE_MAX = 127,
  localparam int VW      = $clog2(VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [VW-1:0] wr_voice,
  input  logic [6:0]    wr_note,
  input  logic          wr_gate,
  input  logic          wr_jump,
  input  logic [13:0]   pitch,
  input  logic [7:0]    lfo_sig,
  input  logic [6:0]    lfo_depth,
  input  logic [6:0]    lfo_depth_fine,
  input  logic [7:0]    glide_rate,
  output logic [31:0]   adder,
  output logic [VW-1:0] adder_voice,
  output logic          adder_valid
);

  // Output handshake: adder_valid is a pure strobe with no ready; adder/adder_voice are
  // meaningful only while it is high, and a new voice result appears every cycle.

  localparam logic signed [19:0] CLAMP_HI = 20'(NOTE_MAX * 256);
  localparam logic [6:0]         NOTE_TOP = 7'(NOTE_MAX);

  // Top-octave increments (notes 120..131 at 50 MHz); lower octaves are right shifts.
  function automatic logic [31:0] note2dds(input logic [6:0] n);
    logic [6:0]  oct;
    logic [6:0]  rem;
    logic [31:0] base;
    oct = n / 7'd12;
    rem = n % 7'd12;
    case (rem)
      7'd0:    base = 32'd719151;
      7'd1:    base = 32'd761914;
      7'd2:    base = 32'd807220;
      7'd3:    base = 32'd855220;
      7'd4:    base = 32'd906074;
      7'd5:    base = 32'd959952;
      7'd6:    base = 32'd1017034;
      7'd7:    base = 32'd1077510;
      7'd8:    base = 32'd1141581;
      7'd9:    base = 32'd1209463;
      7'd10:   base = 32'd1281381;
      default: base = 32'd1357576;
    endcase
    return base >> (7'd10 - oct);
  endfunction

  logic [14:0]   t_mem [VOICES];
  logic [14:0]   p_mem [VOICES];
  logic [VOICES-1:0] g_mem;
  logic [VW-1:0] scan;

  logic          s1_valid, s2_valid, s3_valid;
  logic [VW-1:0] s1_voice, s2_voice, s3_voice;
  logic          s1_g, s2_g, s3_g;
  logic [14:0]   s1_p;
  logic [6:0]    s2_note, s2_note_hi;
  logic [7:0]    s2_frac, s3_frac;
  logic [31:0]   s3_a, s3_b;

  // S0: glide of the scanned voice
  logic [14:0] p_cur, t_cur, p_nxt;
  logic [15:0] up_sum, dn_lim;

  always_comb begin
    p_cur  = p_mem[scan];
    t_cur  = t_mem[scan];
    up_sum = {1'b0, p_cur} + {8'd0, glide_rate};
    dn_lim = {1'b0, t_cur} + {8'd0, glide_rate};
    p_nxt  = p_cur;
    if (glide_rate == 8'd0) begin
      p_nxt = t_cur;
    end else if (p_cur < t_cur) begin
      p_nxt = (up_sum >= {1'b0, t_cur}) ? t_cur : up_sum[14:0];
    end else if (p_cur > t_cur) begin
      p_nxt = ({1'b0, p_cur} > dn_lim) ? (p_cur - {7'd0, glide_rate}) : t_cur;
    end
  end

  // S1: bend, LFO and clamp
  logic signed [19:0] pitch_c, bend, lfo_c, depth_c, fine_c, lfo_val, sum;
  logic [14:0]        clamped;
  logic [6:0]         note_int, note_hi;

  always_comb begin
    pitch_c  = $signed({6'd0, pitch}) - 20'sd8192;
    bend     = (pitch_c * 20'sd12) >>> 5;
    lfo_c    = $signed({12'd0, lfo_sig}) - 20'sd128;
    depth_c  = $signed({13'd0, lfo_depth});
    fine_c   = $signed({13'd0, lfo_depth_fine});
    lfo_val  = (depth_c * lfo_c) + ((fine_c * lfo_c) >>> 7);
    sum      = $signed({5'd0, s1_p}) + bend + lfo_val;
    clamped  = sum[14:0];
    if (sum < 20'sd0)    clamped = 15'd0;
    if (sum > CLAMP_HI)  clamped = CLAMP_HI[14:0];
    note_int = clamped[14:8];
    note_hi  = (note_int >= NOTE_TOP) ? NOTE_TOP : note_int + 7'd1;
  end

  // S3: linear interpolation between adjacent table entries
  logic [8:0]  w_a;
  logic [40:0] mix;

  always_comb begin
    w_a = 9'd256 - {1'b0, s3_frac};
    mix = (41'(s3_a) * 41'(w_a)) + (41'(s3_b) * 41'(s3_frac));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        t_mem[i] <= '0;
        p_mem[i] <= '0;
      end
      g_mem       <= '0;
      scan        <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      s1_voice    <= '0;
      s2_voice    <= '0;
      s3_voice    <= '0;
      s1_g        <= 1'b0;
      s2_g        <= 1'b0;
      s3_g        <= 1'b0;
      s1_p        <= '0;
      s2_note     <= '0;
      s2_note_hi  <= '0;
      s2_frac     <= '0;
      s3_frac     <= '0;
      s3_a        <= '0;
      s3_b        <= '0;
      adder       <= '0;
      adder_voice <= '0;
      adder_valid <= 1'b0;
    end else begin
      scan        <= scan + 1'b1;
      // The later assignments give a same-cycle write priority over the glide result.
      p_mem[scan] <= p_nxt;
      if (wr_en) begin
        t_mem[wr_voice] <= {wr_note, 8'd0};
        g_mem[wr_voice] <= wr_gate;
        if (wr_jump) p_mem[wr_voice] <= {wr_note, 8'd0};
      end

      s1_valid    <= 1'b1;
      s1_voice    <= scan;
      s1_g        <= g_mem[scan];
      s1_p        <= p_nxt;

      s2_valid    <= s1_valid;
      s2_voice    <= s1_voice;
      s2_g        <= s1_g;
      s2_note     <= note_int;
      s2_note_hi  <= note_hi;
      s2_frac     <= clamped[7:0];

      s3_valid    <= s2_valid;
      s3_voice    <= s2_voice;
      s3_g        <= s2_g;
      s3_frac     <= s2_frac;
      s3_a        <= note2dds(s2_note);
      s3_b        <= note2dds(s2_note_hi);

      adder_valid <= s3_valid;
      adder_voice <= s3_voice;
      adder       <= s3_g ? mix[39:8] : 32'd0;
    end
  end

endmodule

// File: doc/poly_note_pitch2dds.md
POLY_NOTE_PITCH2DDS -- requirements
Module: poly_note_pitch2dds

Interface
REQ-001 SHALL have parameter VOICES, default 8, number of voices (power of two, 2..16); VW = log2(VOICES).
REQ-002 SHALL have parameter NOTE_MAX, default 127, highest integer note index passed to the table.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous and active-low.
REQ-005 SHALL have port wr_en  in  1  voice-write strobe; sampled every cycle, always accepted.
REQ-006 SHALL have port wr_voice  in  VW  voice index of the write.
REQ-007 SHALL have port wr_note  in  7  target note 0..127.
REQ-008 SHALL have port wr_gate  in  1  voice active flag written with the note.
REQ-009 SHALL have port wr_jump  in  1  1 = current position jumps to target (no glide).
REQ-010 SHALL have port pitch  in  14  pitch bend, 8192 = centre.
REQ-011 SHALL have port lfo_sig  in  8  LFO sample, 128 = zero.
REQ-012 SHALL have port lfo_depth  in  7  coarse LFO depth.
REQ-013 SHALL have port lfo_depth_fine  in  7  fine LFO depth.
REQ-014 SHALL have port glide_rate  in  8  glide step per scan, 1/256-semitone units; 0 = instant.
REQ-015 SHALL have port adder  out  32  DDS phase increment for adder_voice.
REQ-016 SHALL have port adder_voice  out  VW  voice owning adder.
REQ-017 SHALL have port adder_valid  out  1  adder/adder_voice valid this cycle.

Function
REQ-018 SHALL keep per voice: target T (15-bit, wr_note<<8), position P (15-bit unsigned 7.8), gate G.
REQ-019 SHALL run a free-running scan counter 0..VOICES-1, wrapping to 0, one voice per cycle.
REQ-020 Stage S0 (scan cycle t): glide update of scanned voice: rate 0 -> P=T; P<T -> P=min(P+rate,T); P>T -> P=max(P-rate,T); P=T -> hold.
REQ-021 On wr_en: T[wr_voice]<=wr_note<<8, G<=wr_gate; if wr_jump also P<=wr_note<<8.
REQ-022 When a write and the S0 update hit the same voice in the same cycle, the write SHALL win for T and G, and for P when wr_jump=1; otherwise the glide result is stored for P.
REQ-023 S1: bend = ((pitch-8192)*12)>>>5 (signed, range -3072..+3071); lfo = lfo_depth*(lfo_sig-128) + ((lfo_depth_fine*(lfo_sig-128))>>>7); sum = P+bend+lfo in >=20-bit signed.
REQ-024 S1 SHALL clamp sum to [0, NOTE_MAX*256]; note_int = clamped>>8, frac = clamped[7:0].
REQ-025 S2: two note2dds lookups (one-cycle registered), indices note_int and min(note_int+1, NOTE_MAX).
REQ-026 S3: adder = (A*(256-frac) + B*frac)>>8 with >=41-bit intermediate; frac=0 yields exactly A.
REQ-027 Output register SHALL present the voice scanned at cycle t at cycle t+4: adder_valid=1, adder_voice=that index.
REQ-028 Voice with G=0 at S0 SHALL output adder=0 (valid still 1); its glide still advances.
REQ-029 Steady state SHALL deliver one valid result per cycle, each voice refreshed every VOICES cycles.
REQ-030 pitch, lfo_sig, depths, glide_rate SHALL be sampled at S0/S1 of each slot; changes take effect on the next slot.

Reset
REQ-031 rst_n=0 at an edge SHALL clear all T, P, G, scan counter, pipeline valids; adder=0, adder_voice=0, adder_valid=0 the next cycle.
REQ-032 Reset mid-operation SHALL discard in-flight slots; after release, voice 0 scanned first cycle, first adder_valid 4 cycles later.
REQ-033 Writes during rst_n=0 SHALL be ignored.

Verification
REQ-034 pitch=8192, lfo_sig=128, glide_rate=0, write voice 2 note 69 gate 1 -> voice-2 slots give adder=note2dds(69) exactly, others 0.
REQ-035 Same, pitch=16383 -> position 20735, note_int 80, frac 255 -> adder=(T80*1+T81*255)>>8.
REQ-036 glide_rate=16: jump voice 0 to note 60, then write note 62 without jump -> P rises 15360+16k per scan, reaches 15872 after 32 scans, then holds.
REQ-037 Clamping: note 0, pitch 0 -> adder=note2dds(0); note 127, lfo_sig 255, lfo_depth 127 -> adder=note2dds(127), no wrap.
REQ-038 Write to scanned voice same cycle as its S0 update, rst_n low 1 cycle mid-stream -> write wins per REQ-022; after reset all outputs 0, first valid voice 0 at release+4.
